ps2_poly_note_decoder: RTL and testbench

//  Sequential, polyphonic successor to the combinational scancode-to-note converter.

---
 rtl/ps2_poly_note_decoder.sv | 191 +++++++++++++++++++
 tb/tb_ps2_poly_note_decoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ps2_poly_note_decoder.sv
// Polyphonic PS/2 set-2 note decoder.
// Parses F0 (break) and E0 (extended) prefixes and tracks held note keys in
// NUM_VOICES slots, along with the octave selection and the SPACE/ENTER controls.
module ps2_poly_note_decoder #(
  parameter int NUM_VOICES = 4,
  parameter int OCT_W      = 2,
  parameter int DEF_OCTAVE = 0
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [7:0]                  code_in,
  input  logic                        code_valid,
  output logic [NUM_VOICES*4-1:0]     voice_note,
  output logic [NUM_VOICES*OCT_W-1:0] voice_oct,
  output logic [NUM_VOICES-1:0]       voice_active,
  output logic [OCT_W-1:0]            octave,
  output logic                        load_n,
  output logic                        playback,
  output logic                        key_event,
  output logic                        overflow
);

  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_SPC = 8'h29;
  localparam logic [7:0] CODE_ENT = 8'h5A;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t                        state_q, state_d;
  logic [NUM_VOICES*4-1:0]       note_q, note_d;
  logic [NUM_VOICES*OCT_W-1:0]   oct_q, oct_d;
  logic [NUM_VOICES-1:0]         act_q, act_d;
  logic [OCT_W-1:0]              octave_q, octave_d;
  logic                          load_n_q, load_n_d;
  logic                          playback_q, playback_d;
  logic                          key_event_q, key_event_d;
  logic                          overflow_q, overflow_d;

  logic                          make_ev, brk_ev;
  logic                          hit, found;
  logic [3:0]                    key_note;
  int                            key_oct;

  // Note key to note number (1..12 = A..G#); 0 means not a note key.
  function automatic logic [3:0] note_of(input logic [7:0] c);
    case (c)
      8'h1C: note_of = 4'd1;
      8'h15: note_of = 4'd2;
      8'h1B: note_of = 4'd3;
      8'h23: note_of = 4'd4;
      8'h24: note_of = 4'd5;
      8'h2B: note_of = 4'd6;
      8'h2D: note_of = 4'd7;
      8'h34: note_of = 4'd8;
      8'h33: note_of = 4'd9;
      8'h35: note_of = 4'd10;
      8'h3B: note_of = 4'd11;
      8'h3C: note_of = 4'd12;
      default: note_of = 4'd0;
    endcase
  endfunction

  // Octave key to octave value; -1 means not an octave key.
  function automatic int oct_of(input logic [7:0] c);
    case (c)
      8'h16: oct_of = 0;
      8'h1E: oct_of = 1;
      8'h26: oct_of = 2;
      8'h25: oct_of = 3;
      default: oct_of = -1;
    endcase
  endfunction

  // Only the final byte of an unextended sequence produces an event.
  assign make_ev = code_valid && (state_q == IDLE) &&
                   (code_in != CODE_BRK) && (code_in != CODE_EXT);
  assign brk_ev  = code_valid && (state_q == BRK) && (code_in != CODE_BRK);

  // Prefix parser state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Prefix parser next-state; repeated F0 after a break prefix is absorbed.
  always_comb begin
    state_d = state_q;
    if (code_valid) begin
      case (state_q)
        IDLE:    if (code_in == CODE_BRK)      state_d = BRK;
                 else if (code_in == CODE_EXT) state_d = EXT;
        BRK:     if (code_in != CODE_BRK)      state_d = IDLE;
        EXT:     if (code_in == CODE_BRK)      state_d = EXT_BRK;
                 else                          state_d = IDLE;
        EXT_BRK:                               state_d = IDLE;
        default:                               state_d = IDLE;
      endcase
    end
  end

  // Event handling: voice allocation/release, octave and control keys.
  always_comb begin
    note_d      = note_q;
    oct_d       = oct_q;
    act_d       = act_q;
    octave_d    = octave_q;
    load_n_d    = load_n_q;
    playback_d  = playback_q;
    key_event_d = 1'b0;
    overflow_d  = 1'b0;
    hit         = 1'b0;
    found       = 1'b0;
    key_note    = note_of(code_in);
    key_oct     = oct_of(code_in);
    if (make_ev) begin
      if (key_note != 4'd0) begin
        // A held note re-sent is typematic repeat, not a new voice.
        for (int i = 0; i < NUM_VOICES; i++)
          if (act_q[i] && (note_q[4*i +: 4] == key_note)) hit = 1'b1;
        if (!hit) begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (!found && !act_q[i]) begin
              found                  = 1'b1;
              note_d[4*i +: 4]       = key_note;
              oct_d[OCT_W*i +: OCT_W] = octave_q;
              act_d[i]               = 1'b1;
            end
          end
          if (found) key_event_d = 1'b1;
          else       overflow_d  = 1'b1;
        end
      end else if ((key_oct >= 0) && (key_oct <= (1 << OCT_W) - 1)) begin
        octave_d = OCT_W'(key_oct);
      end else if (code_in == CODE_SPC) begin
        load_n_d = 1'b0;
      end else if (code_in == CODE_ENT) begin
        playback_d = 1'b0;
      end
    end else if (brk_ev) begin
      if (key_note != 4'd0) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (act_q[i] && (note_q[4*i +: 4] == key_note)) begin
            hit                     = 1'b1;
            note_d[4*i +: 4]        = 4'd0;
            oct_d[OCT_W*i +: OCT_W] = '0;
            act_d[i]                = 1'b0;
          end
        end
        key_event_d = hit;
      end else if (code_in == CODE_SPC) begin
        load_n_d = 1'b1;
      end else if (code_in == CODE_ENT) begin
        playback_d = 1'b1;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      note_q      <= '0;
      oct_q       <= '0;
      act_q       <= '0;
      octave_q    <= OCT_W'(DEF_OCTAVE);
      load_n_q    <= 1'b1;
      playback_q  <= 1'b1;
      key_event_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      note_q      <= note_d;
      oct_q       <= oct_d;
      act_q       <= act_d;
      octave_q    <= octave_d;
      load_n_q    <= load_n_d;
      playback_q  <= playback_d;
      key_event_q <= key_event_d;
      overflow_q  <= overflow_d;
    end
  end

  assign voice_note   = note_q;
  assign voice_oct    = oct_q;
  assign voice_active = act_q;
  assign octave       = octave_q;
  assign load_n       = load_n_q;
  assign playback     = playback_q;
  assign key_event    = key_event_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_ps2_poly_note_decoder.sv
// Bench for ps2_poly_note_decoder: table of bytes with expected outputs after
// each byte, followed by hand-written pulse-width and mid-sequence reset cases.
module tb_ps2_poly_note_decoder;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  code_in = 8'h00;
  logic        code_valid = 1'b0;
  logic [15:0] voice_note;
  logic [7:0]  voice_oct;
  logic [3:0]  voice_active;
  logic [1:0]  octave;
  logic        load_n, playback, key_event, overflow;

  ps2_poly_note_decoder #(.NUM_VOICES(4), .OCT_W(2), .DEF_OCTAVE(0)) dut (
    .clock(clock), .resetn(resetn), .code_in(code_in), .code_valid(code_valid),
    .voice_note(voice_note), .voice_oct(voice_oct), .voice_active(voice_active),
    .octave(octave), .load_n(load_n), .playback(playback),
    .key_event(key_event), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  code;
    logic [3:0]  act;
    logic [15:0] note;
    logic [7:0]  oct;
    logic [1:0]  octv;
    logic        ld;
    logic        pb;
    logic        ke;
    logic        ov;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] c, input logic [3:0] a, input logic [15:0] n,
                     input logic [7:0] o, input logic [1:0] ov, input logic ld,
                     input logic pb, input logic ke, input logic of);
    vec_t v;
    v.code = c; v.act = a; v.note = n; v.oct = o; v.octv = ov;
    v.ld = ld; v.pb = pb; v.ke = ke; v.ov = of;
    vecs.push_back(v);
  endtask

  // One byte per call; back-to-back calls give consecutive code_valid cycles.
  task automatic send(input logic [7:0] c);
    @(negedge clock);
    code_in = c;
    code_valid = 1'b1;
    @(posedge clock);
    #1;
    code_valid = 1'b0;
  endtask

  initial begin
    //   code   act    note      oct    octv ld pb ke ov
    // single make, octave change, octave captured at allocation
    add(8'h1C, 4'h1, 16'h0001, 8'h00, 2'd0, 1, 1, 1, 0);
    add(8'h26, 4'h1, 16'h0001, 8'h00, 2'd2, 1, 1, 0, 0);
    add(8'h23, 4'h3, 16'h0041, 8'h08, 2'd2, 1, 1, 1, 0);
    add(8'h16, 4'h3, 16'h0041, 8'h08, 2'd0, 1, 1, 0, 0);
    // fill all slots, then overflow
    add(8'h1B, 4'h7, 16'h0341, 8'h08, 2'd0, 1, 1, 1, 0);
    add(8'h24, 4'hF, 16'h5341, 8'h08, 2'd0, 1, 1, 1, 0);
    add(8'h2B, 4'hF, 16'h5341, 8'h08, 2'd0, 1, 1, 0, 1);
    // release B (slot2) and reuse the slot
    add(8'hF0, 4'hF, 16'h5341, 8'h08, 2'd0, 1, 1, 0, 0);
    add(8'h1B, 4'hB, 16'h5041, 8'h08, 2'd0, 1, 1, 1, 0);
    add(8'h2B, 4'hF, 16'h5641, 8'h08, 2'd0, 1, 1, 1, 0);
    // release slot0, re-make, typematic repeats while full: no overflow
    add(8'hF0, 4'hF, 16'h5641, 8'h08, 2'd0, 1, 1, 0, 0);
    add(8'h1C, 4'hE, 16'h5640, 8'h08, 2'd0, 1, 1, 1, 0);
    add(8'h1C, 4'hF, 16'h5641, 8'h08, 2'd0, 1, 1, 1, 0);
    add(8'h1C, 4'hF, 16'h5641, 8'h08, 2'd0, 1, 1, 0, 0);
    add(8'h1C, 4'hF, 16'h5641, 8'h08, 2'd0, 1, 1, 0, 0);
    // release everything
    add(8'hF0, 4'hF, 16'h5641, 8'h08, 2'd0, 1, 1, 0, 0);
    add(8'h23, 4'hD, 16'h5601, 8'h00, 2'd0, 1, 1, 1, 0);
    add(8'hF0, 4'hD, 16'h5601, 8'h00, 2'd0, 1, 1, 0, 0);
    add(8'h24, 4'h5, 16'h0601, 8'h00, 2'd0, 1, 1, 1, 0);
    add(8'hF0, 4'h5, 16'h0601, 8'h00, 2'd0, 1, 1, 0, 0);
    add(8'h2B, 4'h1, 16'h0001, 8'h00, 2'd0, 1, 1, 1, 0);
    add(8'hF0, 4'h1, 16'h0001, 8'h00, 2'd0, 1, 1, 0, 0);
    add(8'h1C, 4'h0, 16'h0000, 8'h00, 2'd0, 1, 1, 1, 0);
    // break with no matching slot does nothing
    add(8'hF0, 4'h0, 16'h0000, 8'h00, 2'd0, 1, 1, 0, 0);
    add(8'h1C, 4'h0, 16'h0000, 8'h00, 2'd0, 1, 1, 0, 0);
    // extended make and break discarded
    add(8'hE0, 4'h0, 16'h0000, 8'h00, 2'd0, 1, 1, 0, 0);
    add(8'h1C, 4'h0, 16'h0000, 8'h00, 2'd0, 1, 1, 0, 0);
    add(8'hE0, 4'h0, 16'h0000, 8'h00, 2'd0, 1, 1, 0, 0);
    add(8'hF0, 4'h0, 16'h0000, 8'h00, 2'd0, 1, 1, 0, 0);
    add(8'h1C, 4'h0, 16'h0000, 8'h00, 2'd0, 1, 1, 0, 0);
    // parser back in IDLE; double F0 is a single break
    add(8'h1C, 4'h1, 16'h0001, 8'h00, 2'd0, 1, 1, 1, 0);
    add(8'hF0, 4'h1, 16'h0001, 8'h00, 2'd0, 1, 1, 0, 0);
    add(8'hF0, 4'h1, 16'h0001, 8'h00, 2'd0, 1, 1, 0, 0);
    add(8'h1C, 4'h0, 16'h0000, 8'h00, 2'd0, 1, 1, 1, 0);
    // top octave, octave break ignored
    add(8'h25, 4'h0, 16'h0000, 8'h00, 2'd3, 1, 1, 0, 0);
    add(8'h1C, 4'h1, 16'h0001, 8'h03, 2'd3, 1, 1, 1, 0);
    add(8'hF0, 4'h1, 16'h0001, 8'h03, 2'd3, 1, 1, 0, 0);
    add(8'h1C, 4'h0, 16'h0000, 8'h00, 2'd3, 1, 1, 1, 0);
    add(8'hF0, 4'h0, 16'h0000, 8'h00, 2'd3, 1, 1, 0, 0);
    add(8'h16, 4'h0, 16'h0000, 8'h00, 2'd3, 1, 1, 0, 0);
    add(8'h16, 4'h0, 16'h0000, 8'h00, 2'd0, 1, 1, 0, 0);
    // SPACE / ENTER, unmapped bytes hold everything
    add(8'h29, 4'h0, 16'h0000, 8'h00, 2'd0, 0, 1, 0, 0);
    add(8'h5A, 4'h0, 16'h0000, 8'h00, 2'd0, 0, 0, 0, 0);
    add(8'h1C, 4'h1, 16'h0001, 8'h00, 2'd0, 0, 0, 1, 0);
    add(8'h55, 4'h1, 16'h0001, 8'h00, 2'd0, 0, 0, 0, 0);
    add(8'hF0, 4'h1, 16'h0001, 8'h00, 2'd0, 0, 0, 0, 0);
    add(8'h55, 4'h1, 16'h0001, 8'h00, 2'd0, 0, 0, 0, 0);
    add(8'hF0, 4'h1, 16'h0001, 8'h00, 2'd0, 0, 0, 0, 0);
    add(8'h29, 4'h1, 16'h0001, 8'h00, 2'd0, 1, 0, 0, 0);
    add(8'hF0, 4'h1, 16'h0001, 8'h00, 2'd0, 1, 0, 0, 0);
    add(8'h5A, 4'h1, 16'h0001, 8'h00, 2'd0, 1, 1, 0, 0);
    add(8'hF0, 4'h1, 16'h0001, 8'h00, 2'd0, 1, 1, 0, 0);
    add(8'h1C, 4'h0, 16'h0000, 8'h00, 2'd0, 1, 1, 1, 0);

    // reset state
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset voices", {voice_active, voice_note, voice_oct}, 32'h0);
    chk("reset ctrl", {octave, load_n, playback}, {2'd0, 1'b1, 1'b1});
    chk("reset pulses", {key_event, overflow}, 2'b00);
    @(negedge clock);
    resetn = 1'b1;

    // table-driven sequence
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].code);
      chk($sformatf("row%0d voices", i), {voice_active, voice_note, voice_oct},
          {vecs[i].act, vecs[i].note, vecs[i].oct});
      chk($sformatf("row%0d ctrl", i), {octave, load_n, playback},
          {vecs[i].octv, vecs[i].ld, vecs[i].pb});
      chk($sformatf("row%0d pulses", i), {key_event, overflow}, {vecs[i].ke, vecs[i].ov});
    end

    // key_event lasts a single cycle
    @(posedge clock);
    #1;
    chk("key_event width", {key_event, overflow}, 2'b00);

    // reset in the middle of a break sequence
    send(8'h1C);
    send(8'h26);
    send(8'hF0);
    chk("pre-reset state", {voice_active, octave}, {4'h1, 2'd2});
    @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("async reset voices", {voice_active, voice_note, voice_oct}, 32'h0);
    chk("async reset ctrl", {octave, load_n, playback}, {2'd0, 1'b1, 1'b1});
    @(negedge clock);
    resetn = 1'b1;
    send(8'h1C);
    chk("post-reset make", {voice_active, voice_note, voice_oct}, {4'h1, 16'h0001, 8'h00});
    chk("post-reset pulse", {key_event, overflow}, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
